// File: rtl/vga_scanout_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the VGA scan-out path.
// Latency: n/a (declarations only). Backpressure: n/a.
// Framebuffer geometry, counter/address widths and the RGB pixel struct.
package arm_const;

  // Framebuffer geometry: one word per texel, each texel drawn as 4x4 screen pixels.
  localparam int VGA_TEX_W       = 160;
  localparam int VGA_TEX_H       = 120;
  localparam int VGA_SCREEN_SIZE = VGA_TEX_W * VGA_TEX_H;

  // Counter width covers the 800-pixel line and the 525-line frame.
  localparam int VGA_CNT_W  = 10;
  // Texel address width: 19200 words need 15 bits.
  localparam int VGA_ADDR_W = 15;

  typedef logic [VGA_CNT_W-1:0]  vga_cnt_t;
  typedef logic [VGA_ADDR_W-1:0] vga_addr_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_rgb_t;

endpackage

// File: rtl/vga_scanout_timing.sv
`timescale 1ns/1ps
// VGA raster timing: pixel-clock divider, horizontal/vertical counters, area decode.
// Latency: decodes are combinational from the counters; counters step on each pixel tick.
// Backpressure: none, free-running raster.
// Ports: clk/reset in; tick (= divider, also the pixel clock), hc, vc, visible,
//        hsync_act, vsync_act (active-high sync windows), frame_wrap (at 799,524) out.
module vga_timing
  import arm_const::*;
#(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic     clk,
  input  logic     reset,
  output logic     tick,
  output vga_cnt_t hc,
  output vga_cnt_t vc,
  output logic     visible,
  output logic     hsync_act,
  output logic     vsync_act,
  output logic     frame_wrap
);

  localparam vga_cnt_t H_VIS_C  = vga_cnt_t'(H_VIS);
  localparam vga_cnt_t H_LAST   = vga_cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam vga_cnt_t HS_FIRST = vga_cnt_t'(H_VIS + H_FP);
  localparam vga_cnt_t HS_LAST  = vga_cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam vga_cnt_t V_VIS_C  = vga_cnt_t'(V_VIS);
  localparam vga_cnt_t V_LAST   = vga_cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam vga_cnt_t VS_FIRST = vga_cnt_t'(V_VIS + V_FP);
  localparam vga_cnt_t VS_LAST  = vga_cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  logic div;

  // div doubles as the pixel clock; the tick is the clk edge where div falls,
  // so everything updated on the tick is stable at the next pixel-clock rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= 1'b0;
      hc  <= '0;
      vc  <= '0;
    end else begin
      div <= ~div;
      if (div) begin
        if (hc == H_LAST) begin
          hc <= '0;
          if (vc == V_LAST) vc <= '0;
          else              vc <= vc + vga_cnt_t'(1);
        end else begin
          hc <= hc + vga_cnt_t'(1);
        end
      end
    end
  end

  assign tick       = div;
  assign visible    = (hc < H_VIS_C) && (vc < V_VIS_C);
  assign hsync_act  = (hc >= HS_FIRST) && (hc <= HS_LAST);
  assign vsync_act  = (vc >= VS_FIRST) && (vc <= VS_LAST);
  assign frame_wrap = (hc == H_LAST) && (vc == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
`timescale 1ns/1ps
// VGA scan-out: reads the framebuffer word under the beam and drives sync/blank/RGB.
// Latency: outputs trail the raster counters by one pixel (2 clk); sync, blank, RGB aligned.
// Backpressure: none; tex_i is sampled on every tick, mid-frame writes may tear.
// Ports: clk, reset (sync, active high), tex_i[VGA_SCREEN_SIZE] framebuffer words in;
//        vga_clk, hsync_n, vsync_n, blank_n, sync_n, r/g/b, frame_start out.
module vga_scanout
  import arm_const::*;
#(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tex_i [VGA_SCREEN_SIZE],
  output logic        vga_clk,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        sync_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);

  localparam vga_addr_t SCREEN_LIMIT = vga_addr_t'(VGA_SCREEN_SIZE);

  logic     tick;
  vga_cnt_t hc;
  vga_cnt_t vc;
  logic     visible;
  logic     hsync_act;
  logic     vsync_act;
  logic     frame_wrap;

  vga_timing #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .hc         (hc),
    .vc         (vc),
    .visible    (visible),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .frame_wrap (frame_wrap)
  );

  // Texel address ty*160 + tx, built from shifts so no multiplier is inferred.
  vga_addr_t tx;
  vga_addr_t ty;
  vga_addr_t addr;

  assign tx   = vga_addr_t'(hc >> SCALE_SHIFT);
  assign ty   = vga_addr_t'(vc >> SCALE_SHIFT);
  assign addr = (ty << 7) + (ty << 5) + tx;

  // Only read the framebuffer inside the visible area and inside the array;
  // anything else is black. The alpha/unused byte [31:24] is dropped.
  logic [31:0] tex_word;
  vga_rgb_t    texel;
  logic        unused_tex_hi;

  always_comb begin
    tex_word = '0;
    texel    = '0;
    if (visible && (addr < SCREEN_LIMIT)) begin
      tex_word = tex_i[addr];
      texel    = vga_rgb_t'(tex_word[23:0]);
    end
  end

  assign unused_tex_hi = ^tex_word[31:24];

  vga_rgb_t pix_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      pix_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      // Ticks never occur back to back, so this is a single-clk pulse.
      frame_start <= tick && frame_wrap;
      if (tick) begin
        hsync_n <= ~hsync_act;
        vsync_n <= ~vsync_act;
        blank_n <= visible;
        pix_q   <= texel;
      end
    end
  end

  assign vga_clk = tick;
  assign sync_n  = 1'b0;
  assign r       = pix_q.r;
  assign g       = pix_q.g;
  assign b       = pix_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
// Bench for vga_scanout on a shrunken raster (48x19 pixels incl. porches) so that
// several whole frames fit in a short run. Texel mapping is unchanged (160 words/row).
module tb_vga_scanout;
  import arm_const::*;

  // Raster used here: visible 32x12, hsync pixels 36..43, vsync lines 14..15.
  localparam int H_TOT = 48;
  localparam int V_TOT = 19;
  localparam int F_PIX = H_TOT * V_TOT;   // 912 pixels = 1824 clk per frame
  localparam int HS0 = 36, HS1 = 43, VS0 = 14, VS1 = 15, HV = 32, VV = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tex [VGA_SCREEN_SIZE];
  logic        vga_clk, hsync_n, vsync_n, blank_n, sync_n, frame_start;
  logic [7:0]  r, g, b;

  vga_scanout #(
    .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SCALE_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .tex_i(tex),
    .vga_clk(vga_clk), .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n),
    .sync_n(sync_n), .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state: k = clk edges since reset release, seg = 0 before the mid-frame reset.
  int k, seg;
  logic exp_hs, exp_vs, exp_bl, exp_fs;
  logic [23:0] exp_rgb;
  int err_hs, err_vs, err_bl, err_rgb, err_fs, err_misc;
  int hs_low, hs_first, bl_hi, vs_low, vs_first, nfall, nfs, fs_seg1, bad_blank, white;
  int hs_fall [2];
  int fs_k [4];
  logic prev_hs;
  int change_p;
  logic [31:0] change_val;

  // Directed pixels: absolute pixel index since release (segment 0) and expected RGB.
  int tbl_p [12] = '{0, 147, 4, 151, 192, 339, 8, 2383, 1856, 2833, 2834, 2880};
  logic [23:0] tbl_rgb [12] = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
                                24'h0000FF, 24'h0000FF, 24'h000000, 24'hFFFFFF,
                                24'h000000, 24'hFFFFFF, 24'h123456, 24'h123456};

  function automatic logic [31:0] rst_view();
    return {3'b000, hsync_n, vsync_n, blank_n, frame_start, vga_clk, r, g, b};
  endfunction

  task automatic restart_model(input int s);
    k = 0; seg = s;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_bl = 1'b0; exp_fs = 1'b0; exp_rgb = 24'h0;
    prev_hs = 1'b1;
  endtask

  task automatic agg(input string ph);
    check($sformatf("%s hsync_n trace", ph), err_hs, 0);
    check($sformatf("%s vsync_n trace", ph), err_vs, 0);
    check($sformatf("%s blank_n trace", ph), err_bl, 0);
    check($sformatf("%s rgb trace", ph), err_rgb, 0);
    check($sformatf("%s frame_start trace", ph), err_fs, 0);
    check($sformatf("%s vga_clk/sync_n trace", ph), err_misc, 0);
    err_hs = 0; err_vs = 0; err_bl = 0; err_rgb = 0; err_fs = 0; err_misc = 0;
  endtask

  task automatic scan(input int n);
    int p, hc, vc;
    logic exp_ck;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k++;
      if (k >= 2 && (k % 2) == 0) begin
        p  = k / 2 - 1;
        hc = p % H_TOT;
        vc = (p / H_TOT) % V_TOT;
        exp_hs  = !(hc >= HS0 && hc <= HS1);
        exp_vs  = !(vc >= VS0 && vc <= VS1);
        exp_bl  = (hc < HV) && (vc < VV);
        exp_rgb = exp_bl ? tex[(vc / 4) * 160 + hc / 4][23:0] : 24'h0;
        exp_fs  = (p % F_PIX) == F_PIX - 1;
        if (p == 0)
          check($sformatf("seg%0d first tick blank_n+rgb", seg), {7'b0, blank_n, r, g, b},
                {7'b0, 1'b1, (seg == 0) ? 24'hFF0000 : 24'h123456});
        if (seg == 0) begin
          for (int j = 0; j < 12; j++)
            if (tbl_p[j] == p)
              check($sformatf("pixel p=%0d rgb", p), {8'h0, r, g, b}, {8'h0, tbl_rgb[j]});
          if (p < H_TOT) begin
            if (!hsync_n) hs_low++;
            if (!hsync_n && hs_first < 0) hs_first = p;
            if (blank_n) bl_hi++;
          end
          if (p < 2 * F_PIX && !vsync_n) begin
            vs_low++;
            if (vs_first < 0) vs_first = p;
          end
          if (p >= 2 * F_PIX && p < 3 * F_PIX) begin
            if (!blank_n && {r, g, b} != 24'h0) bad_blank++;
            if ({r, g, b} == 24'hFFFFFF) white++;
          end
        end
        if (p == change_p) tex[0] = change_val;
      end else if (k >= 2) begin
        exp_fs = 1'b0;
      end
      exp_ck = (k % 2) == 1;
      if (hsync_n !== exp_hs) err_hs++;
      if (vsync_n !== exp_vs) err_vs++;
      if (blank_n !== exp_bl) err_bl++;
      if ({r, g, b} !== exp_rgb) err_rgb++;
      if (frame_start !== exp_fs) err_fs++;
      if (vga_clk !== exp_ck || sync_n !== 1'b0) err_misc++;
      if (seg == 0) begin
        if (prev_hs === 1'b1 && hsync_n === 1'b0 && nfall < 2) begin
          hs_fall[nfall] = k;
          nfall++;
        end
        if (frame_start === 1'b1) begin
          if (nfs < 4) fs_k[nfs] = k;
          nfs++;
        end
      end else if (frame_start === 1'b1) begin
        fs_seg1++;
      end
      prev_hs = hsync_n;
    end
  endtask

  initial begin
    reset = 1'b1;
    err_hs = 0; err_vs = 0; err_bl = 0; err_rgb = 0; err_fs = 0; err_misc = 0;
    hs_low = 0; hs_first = -1; bl_hi = 0; vs_low = 0; vs_first = -1;
    nfall = 0; nfs = 0; fs_seg1 = 0; bad_blank = 0; white = 0;
    hs_fall = '{0, 0};
    fs_k = '{0, 0, 0, 0};
    change_p = -1; change_val = 32'h0;
    for (int i = 0; i < VGA_SCREEN_SIZE; i++) tex[i] = 32'h0;
    // Top bytes carry junk that must not reach the DAC.
    tex[0]   = 32'hAAFF0000;
    tex[1]   = 32'h5500FF00;
    tex[160] = 32'hC30000FF;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", rst_view(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});

    reset = 1'b0;
    restart_model(0);

    // Two frames: line/frame timing and texel mapping.
    scan(2 * 2 * F_PIX);
    check("line0 hsync_n low ticks", hs_low, 8);
    check("line0 hsync_n first low pixel", hs_first, 36);
    check("line0 blank_n high ticks", bl_hi, 32);
    check("hsync_n first falling edge clk", hs_fall[0], 74);
    check("hsync_n period clk", hs_fall[1] - hs_fall[0], 96);
    check("vsync_n low ticks over 2 frames", vs_low, 192);
    check("vsync_n first low pixel", vs_first, 672);
    check("frame_start pulse count", nfs, 2);
    check("frame_start first edge", fs_k[0], 1824);
    check("frame_start period clk", fs_k[1] - fs_k[0], 1824);
    agg("timing");

    // All-white framebuffer: colour only inside the visible window.
    for (int i = 0; i < VGA_SCREEN_SIZE; i++) tex[i] = 32'h00FFFFFF;
    scan(2 * F_PIX);
    check("rgb nonzero while blanked", bad_blank, 0);
    check("white pixels per frame", white, 384);
    agg("blanking");

    // Rewrite texel 0 while line 2 is being drawn (right after pixel x=1).
    change_p   = 3 * F_PIX + 2 * H_TOT + 1;
    change_val = 32'h00123456;
    scan(2 * F_PIX);
    agg("tex change");

    // Into line 8 of the next frame, then a 3-clk reset.
    scan(2 * (8 * H_TOT + 10));
    check("visible before mid-frame reset", {31'b0, blank_n}, 32'h1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid-frame reset outputs clk%0d", i), rst_view(),
            {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    end
    reset = 1'b0;
    restart_model(1);
    scan(400);
    check("frame_start after restart", fs_seg1, 0);
    agg("restart");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
